// File: rtl/data_mem_ctrl.sv
// Load/store initiator between the core memory stage and a word-write data RAM.
// Sub-word stores are done as read-modify-write; loads return extended data.
module data_mem_ctrl #(
  parameter int unsigned ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_rdata,
  output logic                     resp_error,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic                     ram_write_enable,
  output logic [31:0]              ram_wdata,
  input  logic [31:0]              ram_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                   state_q, state_d;
  logic                     write_q, write_d;
  logic [2:0]               funct3_q, funct3_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]              ram_wdata_q, ram_wdata_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     error_q, error_d;
  logic                     legal, misaligned;

  always_comb begin
    unique case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !req_write;
      default:                legal = 1'b0;
    endcase
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0])
              || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    ram_wdata_d = ram_wdata_q;
    rdata_d     = rdata_q;
    error_d     = error_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr[ADDRESS_WIDTH-1:0];
          rdata_d  = '0;
          error_d  = 1'b0;
          if (!legal || misaligned) begin
            error_d = 1'b1;
            state_d = RESP;
          end else if (req_write) begin
            // Sub-word stores park the store data here until the merge in READ.
            ram_wdata_d = req_wdata;
            state_d     = (req_funct3 == 3'b010) ? WRITE : READ;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (write_q) begin
          ram_wdata_d = funct3_q[0] ? {ram_rdata[31:16], ram_wdata_q[15:0]}
                                    : {ram_rdata[31:8],  ram_wdata_q[7:0]};
          state_d     = WRITE;
        end else begin
          unique case (funct3_q)
            3'b000:  rdata_d = {{24{ram_rdata[7]}},  ram_rdata[7:0]};
            3'b001:  rdata_d = {{16{ram_rdata[15]}}, ram_rdata[15:0]};
            3'b100:  rdata_d = {24'h0, ram_rdata[7:0]};
            3'b101:  rdata_d = {16'h0, ram_rdata[15:0]};
            default: rdata_d = ram_rdata;
          endcase
          state_d = RESP;
        end
      end
      WRITE: state_d = RESP;
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      ram_wdata_q <= ram_wdata_d;
      rdata_q     <= rdata_d;
      error_q     <= error_d;
    end
  end

  assign req_ready        = (state_q == IDLE);
  assign resp_valid       = (state_q == RESP);
  assign ram_write_enable = (state_q == WRITE);
  assign resp_rdata       = rdata_q;
  assign resp_error       = error_q;
  assign ram_address      = addr_q;
  assign ram_wdata        = ram_wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a byte-array RAM, a transaction-level reference
// memory, directed cases and randomized load/store traffic.
module tb_data_mem_ctrl;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk, rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] ram_address;
  logic        ram_write_enable;
  logic [31:0] ram_wdata, ram_rdata;

  logic [7:0] ram [0:255];
  logic [7:0] ref_mem [0:255];

  int unsigned checks = 0;
  int unsigned errors = 0;

  data_mem_ctrl #(.ADDRESS_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .ram_address(ram_address), .ram_write_enable(ram_write_enable),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM window of 256 bytes at BASE, little-endian, four-byte write.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    a0 = ram_address[7:0];
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
    ram_rdata = {ram[a3], ram[a2], ram[a1], ram[a0]};
  end

  always @(posedge clk) begin
    logic [7:0] a0;
    a0 = ram_address[7:0];
    if (ram_write_enable) begin
      ram[a0]        <= ram_wdata[7:0];
      ram[a0 + 8'd1] <= ram_wdata[15:8];
      ram[a0 + 8'd2] <= ram_wdata[23:16];
      ram[a0 + 8'd3] <= ram_wdata[31:24];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_word(input int unsigned off, input logic [31:0] val);
    for (int unsigned k = 0; k < 4; k++) begin
      ram[off + k]     = 8'(val >> (8 * k));
      ref_mem[off + k] = 8'(val >> (8 * k));
    end
  endtask

  function automatic logic [31:0] ref_word(input int unsigned off);
    logic [31:0] w = 0;
    for (int unsigned k = 0; k < 4; k++) w = w + (32'(ref_mem[off + k]) << (8 * k));
    return w;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_req_ready"},  32'(req_ready), 32'd1);
    check_eq({pfx, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check_eq({pfx, "_resp_rdata"}, resp_rdata, 32'd0);
    check_eq({pfx, "_resp_error"}, 32'(resp_error), 32'd0);
    check_eq({pfx, "_ram_addr"},   ram_address, 32'd0);
    check_eq({pfx, "_ram_we"},     32'(ram_write_enable), 32'd0);
    check_eq({pfx, "_ram_wdata"},  ram_wdata, 32'd0);
  endtask

  // One full transaction checked against the reference model.
  task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input int unsigned hold, input bit pulse,
                     output logic [31:0] rd);
    int unsigned size, off, lat, we_cycles, exp_lat;
    bit          err;
    logic [31:0] word, exp_rd, b;
    logic        got_err;
    case (f3)
      3'b000:  size = 1;
      3'b001:  size = 2;
      3'b010:  size = 4;
      3'b100:  size = w ? 0 : 1;
      3'b101:  size = w ? 0 : 2;
      default: size = 0;
    endcase
    err     = (size == 0) || (addr % size != 0);
    off     = addr - BASE;
    word    = ref_word(off);
    exp_rd  = 0;
    if (!err && !w) begin
      case (f3)
        3'b000:  begin b = word % 256;   exp_rd = (b >= 128)   ? b + 32'hFFFF_FF00 : b; end
        3'b001:  begin b = word % 65536; exp_rd = (b >= 32768) ? b + 32'hFFFF_0000 : b; end
        3'b100:  exp_rd = word % 256;
        3'b101:  exp_rd = word % 65536;
        default: exp_rd = word;
      endcase
    end
    if (!err && w)
      for (int unsigned k = 0; k < size; k++) ref_mem[off + k] = 8'(wdata >> (8 * k));
    exp_lat = err ? 1 : (!w ? 2 : (f3 == 3'b010 ? 2 : 3));

    @(negedge clk);
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 1; we_cycles = 0;
    while (!resp_valid && lat < 8) begin
      if (ram_write_enable) we_cycles++;
      @(posedge clk); #1;
      lat++;
    end
    rd      = resp_rdata;
    got_err = resp_error;
    check_eq("latency", lat, exp_lat);
    check_eq("we_cycles", we_cycles, (!err && w) ? 1 : 0);
    check_eq("resp_error", 32'(got_err), 32'(err));
    check_eq("resp_rdata", rd, exp_rd);
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      if (pulse) begin
        req_valid = 1'(i % 2 == 0); req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = addr & ~32'h3; req_wdata = 32'hBAD0_0BAD;
      end
      check_eq("hold_valid", 32'(resp_valid), 32'd1);
      check_eq("hold_rdata", resp_rdata, rd);
      check_eq("hold_error", 32'(resp_error), 32'(got_err));
      check_eq("hold_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check_eq("resp_done", 32'(resp_valid), 32'd0);
    check_eq("ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    for (int unsigned i = 0; i < 256; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b0;

    // Reset in the middle of a word store.
    set_word(0, 32'h8899_AABB);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = BASE; req_wdata = 32'h1122_3344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("sw_in_write", 32'(ram_write_enable), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_ram_word", {ram[3], ram[2], ram[1], ram[0]}, 32'h8899_AABB);
    check_reset_outputs("rst_after");

    // Loads of each width and sign.
    txn(1'b0, 3'b000, BASE, 0, 0, 0, rd); check_eq("lb",  rd, 32'hFFFF_FFBB);
    txn(1'b0, 3'b100, BASE, 0, 0, 0, rd); check_eq("lbu", rd, 32'h0000_00BB);
    txn(1'b0, 3'b001, BASE, 0, 0, 0, rd); check_eq("lh",  rd, 32'hFFFF_AABB);
    txn(1'b0, 3'b101, BASE, 0, 0, 0, rd); check_eq("lhu", rd, 32'h0000_AABB);
    txn(1'b0, 3'b010, BASE, 0, 0, 0, rd); check_eq("lw",  rd, 32'h8899_AABB);

    txn(1'b1, 3'b010, BASE + 4, 32'hDEAD_BEEF, 0, 0, rd);
    txn(1'b0, 3'b010, BASE + 4, 0, 0, 0, rd); check_eq("lw_after_sw", rd, 32'hDEAD_BEEF);

    set_word(8, 32'h8899_AABB);
    txn(1'b1, 3'b000, BASE + 8, 32'h0000_00EE, 0, 0, rd);
    txn(1'b0, 3'b010, BASE + 8, 0, 0, 0, rd); check_eq("lw_after_sb", rd, 32'h8899_AAEE);
    txn(1'b1, 3'b001, BASE + 8, 32'h0000_1234, 0, 0, rd);
    txn(1'b0, 3'b010, BASE + 8, 0, 0, 0, rd); check_eq("lw_after_sh", rd, 32'h8899_1234);

    // Misaligned and illegal requests.
    txn(1'b0, 3'b001, BASE + 1, 0, 0, 0, rd);
    txn(1'b1, 3'b010, BASE + 2, 32'hCAFE_F00D, 0, 0, rd);
    txn(1'b0, 3'b011, BASE, 0, 0, 0, rd);
    check_eq("err_ram_word", {ram[3], ram[2], ram[1], ram[0]}, 32'h8899_AABB);

    // Response back-pressure with requests presented meanwhile.
    txn(1'b0, 3'b010, BASE + 4, 0, 5, 1, rd); check_eq("lw_held", rd, 32'hDEAD_BEEF);

    for (int unsigned n = 0; n < 120; n++) begin
      logic [31:0] a;
      a = BASE + $urandom_range(0, 252);
      txn(1'($urandom), 3'($urandom), a, $urandom, $urandom_range(0, 3),
          1'($urandom), rd);
    end

    for (int unsigned i = 0; i < 256; i++)
      check_eq("ram_final", 32'(ram[i]), 32'(ref_mem[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Load/store initiator that sits between the single-cycle core's memory stage and the byte-addressed data RAM. It accepts one CPU request at a time over a valid/ready handshake and decodes RV32I funct3 widths. The data RAM always writes four bytes, so sub-word stores are done as read-modify-write. Loads are returned sign- or zero-extended, and misaligned or illegal requests get an error response without touching the RAM.

## Interface
- ADDRESS_WIDTH, 32, width of the RAM byte address; `req_addr` is truncated to its low ADDRESS_WIDTH bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  the CPU is presenting a request.
- req_ready  out  1  the block can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  access width and sign, RV32I encoding.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low bytes are used for SB/SH.
- resp_valid  out  1  response is available; high only in RESP.
- resp_ready  in  1  the CPU accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  the request was misaligned or had an illegal funct3.
- ram_address  out  ADDRESS_WIDTH  RAM byte address, driven from a register.
- ram_write_enable  out  1  RAM write strobe; high only in WRITE.
- ram_wdata  out  32  RAM write data, driven from a register.
- ram_rdata  in  32  combinational RAM read data for the word at bytes address+3..address, little-endian.

## Operation
- States: IDLE, READ, WRITE, RESP.
- Handshake: a request is accepted on a rising edge where `req_valid && req_ready`. On acceptance the block latches write, funct3, the truncated address and wdata.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal.
- Alignment rules:
  - Halfword accesses require addr[0]=0.
  - Word accesses require addr[1:0]=00.
  - Byte accesses are always aligned.
- Transitions out of IDLE on acceptance:
  - Illegal or misaligned request → RESP with error=1.
  - Load → READ.
  - SW → WRITE, with `ram_wdata` = req_wdata.
  - SB/SH → READ.
- READ:
  - For a load, latch `ram_rdata` into a 32-bit register and go to RESP.
  - For SB/SH, build merged data: old word with bits [7:0] (SB) or [15:0] (SH) replaced from wdata. Load it into `ram_wdata` and go to WRITE.
- WRITE: `ram_write_enable`=1 for exactly one cycle, then go to RESP.
- RESP:
  - `resp_valid` stays high and `resp_rdata`/`resp_error` stay stable until `resp_ready` is sampled high; then go to IDLE.
  - A new request can be accepted no earlier than the cycle after the RESP handshake.
- Load extension of the captured word:
  - LB sign-extends bits [7:0]; LBU zero-extends them.
  - LH sign-extends bits [15:0]; LHU zero-extends them.
  - LW returns the word unchanged.
- `ram_address` holds the latched address from acceptance until the next acceptance. The RAM is never written for loads or errors.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0, `ram_address`=0, `ram_write_enable`=0, `ram_wdata`=0.
- `ram_write_enable` and `req_ready` decode directly from the state register, so asserting `rst` drops the write strobe immediately.
- Reset mid-operation: the transaction is abandoned with no RAM write and no response. A partially merged SB/SH is never written.
- Latency in cycles, from the acceptance edge E0 to the first cycle with `resp_valid`=1:
  - Error: 1 (RESP after E0).
  - Load: 2 (READ after E0, RESP after E1).
  - SW: 2 (WRITE after E0; the RAM commits at E1).
  - SB/SH: 3 (READ, WRITE, RESP; the RAM commits at E2).
- When `resp_ready` is held high, the response handshake takes 1 cycle.
- Throughput: at most one request in flight.
- `req_valid` asserted during READ/WRITE/RESP is ignored, because `req_ready`=0. The CPU must keep its request stable until it is accepted.

## Test plan
- Reset with `rst` pulsed mid-WRITE of SW 0x11223344 @0x10000 → `ram_write_enable` falls with `rst`, RAM word unchanged, all outputs at reset values, `req_ready`=1.
- RAM word @0x10000 = 0x8899AABB:
  - LB @0x10000 → resp_rdata 0xFFFFFFBB.
  - LBU → 0x000000BB.
  - LH → 0xFFFFAABB.
  - LHU → 0x0000AABB.
  - LW → 0x8899AABB.
  - Each response appears 2 cycles after acceptance.
- SW 0xDEADBEEF @0x10004, then LW @0x10004 → 0xDEADBEEF. `ram_write_enable` is high for exactly 1 cycle.
- Word @0x10008 = 0x8899AABB:
  - SB 0x000000EE @0x10008 → LW returns 0x8899AAEE.
  - Then SH 0x00001234 @0x10008 → LW returns 0x88991234.
  - Each store response appears 3 cycles after acceptance.
- LH @0x10001, SW @0x10002, and funct3=011 load → resp_error=1 and resp_rdata=0 one cycle after acceptance. No RAM write occurs.
- Hold `resp_ready`=0 for 5 cycles after an LW response → `resp_valid` and `resp_rdata` stay stable and `req_ready` stays 0; `req_valid` pulses during this time are not accepted.
